// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with prescaled count steps, pause/resume and an
// optional reload-on-zero mode. Drives the tens/units digits of a display.
module bcd_down_counter #(
  parameter int TICK_DIV = 100000000,
  parameter bit WRAP     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] start_hi,
  input  logic [3:0] start_lo,
  input  logic       run,
  output logic [3:0] bcd_hi,
  output logic [3:0] bcd_lo,
  output logic       busy,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre;
  logic [3:0]    rel_hi, rel_lo;
  logic [3:0]    cl_hi, cl_lo;
  logic          tick, at_zero, last_step;

  assign cl_hi     = (start_hi > 4'd9) ? 4'd9 : start_hi;
  assign cl_lo     = (start_lo > 4'd9) ? 4'd9 : start_lo;
  assign at_zero   = (bcd_hi == 4'd0) && (bcd_lo == 4'd0);
  assign last_step = (bcd_hi == 4'd0) && (bcd_lo == 4'd1);
  // Dropping run pauses immediately, so a pending tick is held, not consumed.
  assign tick      = (state == RUN) && run && (pre == PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (run) state_nxt = at_zero ? DONE : RUN;
        RUN:     if (!run) state_nxt = PAUSE;
                 else if (tick && last_step && !WRAP) state_nxt = DONE;
        PAUSE:   if (run) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN) || (state == PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre    <= '0;
      bcd_hi <= 4'd0;
      bcd_lo <= 4'd0;
      rel_hi <= 4'd0;
      rel_lo <= 4'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        pre    <= '0;
        bcd_hi <= cl_hi;
        bcd_lo <= cl_lo;
        rel_hi <= cl_hi;
        rel_lo <= cl_lo;
      end else begin
        case (state)
          IDLE: if (run && at_zero) done <= 1'b1;
          RUN: if (run) begin
            if (tick) begin
              pre <= '0;
              if (last_step) begin
                done <= 1'b1;
                // Reload skips the 00 display entirely in wrap mode.
                bcd_hi <= WRAP ? rel_hi : 4'd0;
                bcd_lo <= WRAP ? rel_lo : 4'd0;
              end else if (bcd_lo != 4'd0) begin
                bcd_lo <= bcd_lo - 4'd1;
              end else begin
                bcd_lo <= 4'd9;
                bcd_hi <= bcd_hi - 4'd1;
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: a stop-at-zero and a wrap instance share stimulus
// and are compared every cycle against an integer-valued reference model.
module tb_bcd_down_counter;
  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, load, run;
  logic [3:0] start_hi, start_lo;
  logic [3:0] hi0, lo0, hi1, lo1;
  logic       busy0, busy1, done0, done1;
  logic [9:0] obs [2];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.TICK_DIV(TD), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .start_hi(start_hi), .start_lo(start_lo),
    .run(run), .bcd_hi(hi0), .bcd_lo(lo0), .busy(busy0), .done(done0));
  bcd_down_counter #(.TICK_DIV(TD), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .start_hi(start_hi), .start_lo(start_lo),
    .run(run), .bcd_hi(hi1), .bcd_lo(lo1), .busy(busy1), .done(done1));

  assign obs[0] = {hi0, lo0, busy0, done0};
  assign obs[1] = {hi1, lo1, busy1, done1};

  // Reference model: value held as an integer 0..99; index 1 is the wrap variant.
  int   m_val [2], m_pre [2], m_rel [2], m_mode [2];
  logic m_done [2];

  function automatic int clamp(logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < 2; w++) begin
        m_val[w] = 0; m_pre[w] = 0; m_rel[w] = 0; m_mode[w] = M_IDLE; m_done[w] = 1'b0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        m_done[w] = 1'b0;
        if (load) begin
          m_val[w] = clamp(start_hi) * 10 + clamp(start_lo);
          m_rel[w] = m_val[w]; m_pre[w] = 0; m_mode[w] = M_IDLE;
        end else begin
          case (m_mode[w])
            M_IDLE: if (run) begin
              if (m_val[w] == 0) begin m_mode[w] = M_DONE; m_done[w] = 1'b1; end
              else m_mode[w] = M_RUN;
            end
            M_RUN: if (!run) m_mode[w] = M_PAUSE;
              else if (m_pre[w] == TD - 1) begin
                m_pre[w] = 0;
                if (m_val[w] == 1) begin
                  m_done[w] = 1'b1;
                  if (w == 1) m_val[w] = m_rel[w];
                  else begin m_val[w] = 0; m_mode[w] = M_DONE; end
                end else m_val[w] = m_val[w] - 1;
              end else m_pre[w] = m_pre[w] + 1;
            M_PAUSE: if (run) m_mode[w] = M_RUN;
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [9:0] model_out(int w);
    logic b;
    b = (m_mode[w] == M_RUN) || (m_mode[w] == M_PAUSE);
    return {4'(m_val[w] / 10), 4'(m_val[w] % 10), b, m_done[w]};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] l);
    load = 1'b1; start_hi = h; start_lo = l;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; run = 1'b1; start_hi = 4'd9; start_lo = 4'd9;
    cyc(); cyc();
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (obs[w] !== 10'h000) begin
        fails++; $display("FAIL reset w%0d: got %h want 000", w, obs[w]);
      end
    end
    load = 1'b0; run = 1'b0; rst = 1'b0;
    cyc();
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (obs[w] !== model_out(w)) begin
        fails++; $display("FAIL reset_release w%0d: got %h want %h", w, obs[w], model_out(w));
      end
    end
  endtask

  task automatic test_countdown();
    int seq [$]; int at [$]; int v;
    int exp_seq [4] = '{12, 11, 10, 9};
    do_load(4'd1, 4'd2);
    seq.push_back(hi0 * 10 + lo0); at.push_back(0);
    run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      for (int w = 0; w < 2; w++) begin
        tests++;
        if (obs[w] !== model_out(w)) begin
          fails++; $display("FAIL countdown w%0d c%0d: got %h want %h", w, c, obs[w], model_out(w));
        end
      end
      v = hi0 * 10 + lo0;
      if (v != seq[$]) begin seq.push_back(v); at.push_back(c); end
    end
    // Listing only distinct values proves the 10->09 borrow takes one edge.
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (seq.size() <= i || seq[i] != exp_seq[i]) begin
        fails++; $display("FAIL countdown_seq[%0d]: got %0d want %0d", i,
                          (seq.size() > i) ? seq[i] : -1, exp_seq[i]);
      end
    end
    tests++;
    if (at.size() < 3 || at[2] - at[1] != TD) begin
      fails++; $display("FAIL countdown_period: got %0d want %0d",
                        (at.size() >= 3) ? at[2] - at[1] : -1, TD);
    end
    run = 1'b0;
  endtask

  task automatic test_done_and_wrap();
    int p0 = 0, p1 = 0, mp1 = 0, zero1 = 0;
    do_load(4'd0, 4'd2);
    run = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      for (int w = 0; w < 2; w++) begin
        tests++;
        if (obs[w] !== model_out(w)) begin
          fails++; $display("FAIL done_wrap w%0d c%0d: got %h want %h", w, c, obs[w], model_out(w));
        end
      end
      p0 += int'(done0); p1 += int'(done1); mp1 += int'(m_done[1]);
      if (hi1 == 4'd0 && lo1 == 4'd0) zero1++;
    end
    tests++;
    if (p0 != 1) begin fails++; $display("FAIL stop_done_pulses: got %0d want 1", p0); end
    tests++;
    if ({hi0, lo0, busy0} !== 9'h000) begin
      fails++; $display("FAIL stop_final: got %h want 000", {hi0, lo0, busy0});
    end
    tests++;
    if (p1 < 2 || p1 != mp1) begin fails++; $display("FAIL wrap_done_pulses: got %0d want %0d", p1, mp1); end
    tests++;
    if (zero1 != 0) begin fails++; $display("FAIL wrap_zero_shown: got %0d want 0", zero1); end
    run = 1'b0;
  endtask

  task automatic test_pause();
    int edges = 0;
    do_load(4'd0, 4'd5);
    run = 1'b1;
    cyc(); cyc(); cyc();           // enter RUN, then two prescaler steps
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      tests++;
      if (obs[0] !== model_out(0) || {hi0, lo0} !== 8'h05) begin
        fails++; $display("FAIL pause_hold c%0d: got %h want %h", c, obs[0], model_out(0));
      end
    end
    run = 1'b1;
    // Edge 1 resumes RUN, edge 2 reaches the last prescale count, edge 3 steps.
    while (lo0 == 4'd5 && edges < 10) begin cyc(); edges++; end
    tests++;
    if (edges != 3 || lo0 !== 4'd4) begin
      fails++; $display("FAIL pause_resume: got %0d edges value %0d want 3 edges value 4", edges, lo0);
    end
    run = 1'b0;
  endtask

  task automatic test_load_priority();
    int guard = 0;
    do_load(4'd0, 4'd5);
    run = 1'b1;
    while (!(m_mode[0] == M_RUN && m_pre[0] == TD - 1) && guard < 20) begin cyc(); guard++; end
    tests++;
    if (guard >= 20) begin fails++; $display("FAIL load_prio_timeout: got %0d want <20", guard); end
    do_load(4'd15, 4'd12);
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (obs[w] !== {4'd9, 4'd9, 1'b0, 1'b0}) begin
        fails++; $display("FAIL load_prio w%0d: got %h want 990", w, obs[w]);
      end
    end
    cyc();
    do_load(4'd0, 4'd0);           // run still 1
    cyc();
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (obs[w] !== 10'h001) begin
        fails++; $display("FAIL load_zero_done w%0d: got %h want 001", w, obs[w]);
      end
    end
    cyc();
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (obs[w] !== 10'h000) begin
        fails++; $display("FAIL load_zero_after w%0d: got %h want 000", w, obs[w]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_load(4'd0, 4'd9);
    run = 1'b1;
    while (m_val[0] != 7 && guard < 30) begin cyc(); guard++; end
    tests++;
    if (obs[0] !== model_out(0) || guard >= 30) begin
      fails++; $display("FAIL rst_mid_reach: got %h want %h", obs[0], model_out(0));
    end
    #2 rst = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      tests++;
      if (obs[w] !== 10'h000) begin
        fails++; $display("FAIL rst_mid_async w%0d: got %h want 000", w, obs[w]);
      end
    end
    cyc();
    tests++;
    if ({done0, done1, busy0, busy1} !== 4'b0) begin
      fails++; $display("FAIL rst_mid_hold: got %b want 0000", {done0, done1, busy0, busy1});
    end
    rst = 1'b0; run = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc();
      for (int w = 0; w < 2; w++) begin
        tests++;
        if (obs[w] !== model_out(w)) begin
          fails++; $display("FAIL random w%0d c%0d: got %h want %h", w, c, obs[w], model_out(w));
        end
      end
      load     = ($urandom_range(0, 24) == 0);
      start_hi = 4'($urandom_range(0, 15));
      start_lo = 4'($urandom_range(0, 15));
      run      = ($urandom_range(0, 9) != 0);
    end
    load = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_done_and_wrap();
    test_pause();
    test_load_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
